uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter with a ready/valid input, a 1-entry holding register and per-frame

---
 rtl/uart_tx_cfg_if.sv | 27 ++
 rtl/uart_tx_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Host-side byte offer channel for uart_tx_cfg.
// Carries payload plus per-frame parity/stop settings.
interface uart_tx_cfg_if #(
    parameter int DBIT = 8
) ();
    logic            tx_valid;
    logic            tx_ready;
    logic [DBIT-1:0] tx_data;
    logic [1:0]      parity_mode;
    logic            stop2;

    modport master (
        output tx_valid,
        output tx_data,
        output parity_mode,
        output stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  parity_mode,
        input  stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with 1-entry holding register and
// per-frame parity / stop-bit configuration.
module uart_tx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         stick,
    uart_tx_cfg_if.slave host,
    output logic         tx_done,
    output logic         busy,
    output logic         tx
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DBIT);

    localparam logic [TW-1:0] OS_M1    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP2_M1 = TW'(2 * OVERSAMPLE - 1);
    localparam logic [BW-1:0] DB_M1    = BW'(DBIT - 1);

    generate
        if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
            $error("uart_tx_cfg: DBIT must be 5..9");
        end
        if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_os
            $error("uart_tx_cfg: OVERSAMPLE must be 4..32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state;
    logic            hr_full;
    logic [DBIT-1:0] hr_data;
    logic [1:0]      hr_mode;
    logic            hr_stop2;
    logic [DBIT-1:0] shifter;
    logic            par_en;
    logic            par_bit;
    logic            f_stop2;
    logic [TW-1:0]   tick;
    logic [BW-1:0]   bcnt;
    logic            hs;
    logic            bit_end;
    logic            stop_end;

    assign host.tx_ready = ~hr_full;
    assign busy          = (state != S_IDLE) | hr_full;

    // Handshake and end-of-period decodes for the FSM below.
    always_comb begin
        hs       = host.tx_valid & ~hr_full;
        bit_end  = stick & (tick == OS_M1);
        stop_end = stick & (tick == (f_stop2 ? STOP2_M1 : OS_M1));
    end

    // Frame sequencer, holding register and registered line/done outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            hr_full  <= 1'b0;
            hr_data  <= '0;
            hr_mode  <= 2'b00;
            hr_stop2 <= 1'b0;
            shifter  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            f_stop2  <= 1'b0;
            tick     <= '0;
            bcnt     <= '0;
            tx_done  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_done <= 1'b0;

            if (hs) begin
                hr_full  <= 1'b1;
                hr_data  <= host.tx_data;
                hr_mode  <= host.parity_mode;
                hr_stop2 <= host.stop2;
            end

            unique case (state)
                S_IDLE: begin
                    if (hr_full) begin
                        shifter <= hr_data;
                        par_en  <= hr_mode[0] ^ hr_mode[1];
                        par_bit <= hr_mode[1] ? ^hr_data : ~^hr_data;
                        f_stop2 <= hr_stop2;
                        tick    <= '0;
                        bcnt    <= '0;
                        if (!hs) hr_full <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tick  <= '0;
                        state <= S_DATA;
                    end else if (stick) begin
                        tick <= tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        tick    <= '0;
                        shifter <= shifter >> 1;
                        if (bcnt == DB_M1) begin
                            bcnt  <= '0;
                            state <= par_en ? S_PARITY : S_STOP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else if (stick) begin
                        tick <= tick + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tick  <= '0;
                        state <= S_STOP;
                    end else if (stick) begin
                        tick <= tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_end) begin
                        tick    <= '0;
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end else if (stick) begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            unique case (state)
                S_START:  tx <= 1'b0;
                S_DATA:   tx <= shifter[0];
                S_PARITY: tx <= par_bit;
                default:  tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames plus random traffic
// against a frame-level reference model.
module tb_uart_tx_cfg;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic stick = 1'b0;
    logic tx_done;
    logic busy;
    logic tx;

    uart_tx_cfg_if #(.DBIT(8)) ifc ();

    uart_tx_cfg #(
        .DBIT       (8),
        .OVERSAMPLE (OS)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .stick   (stick),
        .host    (ifc),
        .tx_done (tx_done),
        .busy    (busy),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int done_seen = 0;
    int stick_per = 1;
    int sc = 0;
    bit chk_en = 1'b0;
    bit rec = 1'b0;
    logic tq[$];
    logic dq[$];

    // reference model state: held frame, active frame as a level list
    logic        m_full = 1'b0;
    logic [7:0]  m_hd = 8'h00;
    logic [1:0]  m_hm = 2'b00;
    logic        m_hs = 1'b0;
    logic        m_act = 1'b0;
    logic [15:0] m_lv = '1;
    int          m_nb = 0;
    int          m_sk = 0;
    logic        m_tx = 1'b1;
    logic        m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Line levels of one frame, one entry per bit period.
    function automatic logic [15:0] frame_lv(input logic [7:0] d,
                                             input logic [1:0] m);
        logic [15:0] v;
        int n;
        v = '1;
        v[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            v[n] = d[i];
            n++;
        end
        if (m == 2'b01 || m == 2'b10)
            v[n] = ((m == 2'b10) == ($countones(d) % 2 == 1));
        return v;
    endfunction

    function automatic int frame_nb(input logic [1:0] m, input logic s2);
        return 10 + ((m == 2'b01 || m == 2'b10) ? 1 : 0) + (s2 ? 1 : 0);
    endfunction

    // Stick pulse every stick_per clocks.
    always @(negedge clk) begin
        if (sc + 1 >= stick_per) begin
            sc <= 0;
            stick <= 1'b1;
        end else begin
            sc <= sc + 1;
            stick <= 1'b0;
        end
    end

    // Reference model: frame position counted in sticks; line lags one clk.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_full <= 1'b0;
            m_act  <= 1'b0;
            m_sk   <= 0;
            m_tx   <= 1'b1;
            m_done <= 1'b0;
        end else begin
            m_tx   <= m_act ? m_lv[m_sk / OS] : 1'b1;
            m_done <= 1'b0;
            if (m_act) begin
                if (stick) begin
                    if (m_sk + 1 == m_nb * OS) begin
                        m_act  <= 1'b0;
                        m_sk   <= 0;
                        m_done <= 1'b1;
                    end else begin
                        m_sk <= m_sk + 1;
                    end
                end
            end else if (m_full) begin
                m_lv   <= frame_lv(m_hd, m_hm);
                m_nb   <= frame_nb(m_hm, m_hs);
                m_sk   <= 0;
                m_act  <= 1'b1;
                m_full <= 1'b0;
            end
            if (ifc.tx_valid && !m_full) begin
                m_full <= 1'b1;
                m_hd   <= ifc.tx_data;
                m_hm   <= ifc.parity_mode;
                m_hs   <= ifc.stop2;
            end
        end
    end

    // Per-cycle comparison against the model and line recording.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", tx, m_tx);
            chk("tx_done", tx_done, m_done);
            chk("busy", busy, m_act | m_full);
            chk("tx_ready", ifc.tx_ready, !m_full);
            if (tx_done) done_seen <= done_seen + 1;
            if (rec) begin
                tq.push_back(tx);
                dq.push_back(tx_done);
            end
        end
    end

    function automatic int idx_tx(input logic v, input int from);
        if (from < 0) return -1;
        for (int i = from; i < tq.size(); i++)
            if (tq[i] === v) return i;
        return -1;
    endfunction

    function automatic int idx_done(input int from);
        if (from < 0) return -1;
        for (int i = from; i < dq.size(); i++)
            if (dq[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done();
        int c;
        c = 0;
        for (int i = 0; i < dq.size(); i++)
            if (dq[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic logic [7:0] decode(input int b0, input int bw);
        logic [7:0] v;
        v = 8'h00;
        if (b0 < 0) return 8'hxx;
        for (int i = 0; i < 8; i++)
            if (b0 + i * bw + bw / 2 < tq.size())
                v[i] = tq[b0 + i * bw + bw / 2];
        return v;
    endfunction

    task automatic push(input logic [7:0] d, input logic [1:0] m,
                        input logic s2);
        int k;
        logic r;
        k = 0;
        @(negedge clk);
        ifc.tx_valid = 1'b1;
        ifc.tx_data = d;
        ifc.parity_mode = m;
        ifc.stop2 = s2;
        forever begin
            r = ifc.tx_ready;
            @(posedge clk);
            if (r) break;
            k++;
            if (k > 2000) begin
                chk("push_accept", r, 1);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ifc.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rec_on();
        tq.delete();
        dq.delete();
        rec = 1'b1;
    endtask

    initial begin
        int f;
        int d;
        int d1;
        int f2;
        int d2;
        int r1;
        int r2;
        int ds;
        int nfr;

        ifc.tx_valid = 1'b0;
        ifc.tx_data = 8'h00;
        ifc.parity_mode = 2'b00;
        ifc.stop2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", ifc.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        rstn = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55, no parity, 1 stop
        rec_on();
        push(8'h55, 2'b00, 1'b0);
        chk("lat_hs", tx, 1);
        @(negedge clk);
        chk("lat_load", tx, 1);
        @(negedge clk);
        chk("lat_fall", tx, 0);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        d = idx_done(f);
        chk("t1_len", d - f + 1, 160);
        chk("t1_start", idx_tx(1, f) - f, 16);
        chk("t1_data", decode(f + 16, 16), 8'h55);
        chk("t1_dones", count_done(), 1);

        // 0x07 even then odd parity
        rec_on();
        push(8'h07, 2'b10, 1'b0);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        d = idx_done(f);
        chk("t2e_len", d - f + 1, 176);
        chk("t2e_par", tq[f + 9 * 16 + 8], 1);
        rec_on();
        push(8'h07, 2'b01, 1'b0);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        d = idx_done(f);
        chk("t2o_len", d - f + 1, 176);
        chk("t2o_par", tq[f + 9 * 16 + 8], 0);

        // 0xFF, two stop bits
        rec_on();
        push(8'hFF, 2'b00, 1'b1);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        d = idx_done(f);
        chk("t3_len", d - f + 1, 176);
        chk("t3_high", idx_tx(0, f + 16), -1);

        // back-to-back with holding register and stall
        rec_on();
        push(8'hA5, 2'b00, 1'b0);
        push(8'h3C, 2'b00, 1'b0);
        chk("t4_held", ifc.tx_ready, 0);
        push(8'h81, 2'b00, 1'b0);
        wait_idle();
        rec = 1'b0;
        chk("t4_dones", count_done(), 3);
        f = idx_tx(0, 0);
        d1 = idx_done(f);
        chk("t4_d1", decode(f + 16, 16), 8'hA5);
        f2 = idx_tx(0, d1);
        chk("t4_gap", f2 - d1, 2);
        d2 = idx_done(d1 + 1);
        chk("t4_len2", d2 - f2 + 1, 160);
        chk("t4_d2", decode(f2 + 16, 16), 8'h3C);
        chk("t4_d3", decode(idx_tx(0, d2) + 16, 16), 8'h81);

        // slow stick
        stick_per = 4;
        rec_on();
        push(8'h55, 2'b00, 1'b0);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        r1 = idx_tx(1, f);
        r2 = idx_tx(0, r1);
        chk("t5_bit", r2 - r1, 64);
        chk("t5_data", decode(r1, 64), 8'h55);
        chk("t5_dones", count_done(), 1);
        stick_per = 1;

        // reset in the middle of the data phase
        ds = done_seen;
        push(8'h3C, 2'b00, 1'b0);
        repeat (40) @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_tx", tx, 1);
        chk("t6_ready", ifc.tx_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_done", tx_done, 0);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_nodone", done_seen, ds);
        rec_on();
        push(8'h96, 2'b10, 1'b1);
        wait_idle();
        rec = 1'b0;
        f = idx_tx(0, 0);
        d = idx_done(f);
        chk("t6_len", d - f + 1, 192);
        chk("t6_data", decode(f + 16, 16), 8'h96);

        // random traffic, model checks every cycle
        ds = done_seen;
        nfr = 0;
        for (int i = 0; i < 24; i++) begin
            stick_per = $urandom_range(1, 3);
            push(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
            nfr++;
            if ($urandom_range(0, 3) == 0)
                wait_idle();
            else
                repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        chk("rnd_dones", done_seen - ds, nfr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
